// File: rtl/physics_pkg.sv
// Shared definitions for the sprite physics stage: widths, per-sprite state,
// sequencer states and the saturate/clamp helpers.
package physics_pkg;

    localparam int unsigned NUM_SPRITES   = 4;
    localparam int unsigned SPRITE_RADIUS = 63;
    localparam int unsigned H_VISIBLE     = 1600;
    localparam int unsigned V_VISIBLE     = 1200;

    localparam int unsigned ROW_W   = 11;
    localparam int unsigned COL_W   = 12;
    localparam int unsigned VEL_W   = 8;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned FRAME_W = 16;
    localparam int unsigned WIDE_W  = 16;

    typedef struct packed {
        logic [ROW_W-1:0]        row;
        logic [COL_W-1:0]        col;
        logic signed [VEL_W-1:0] vrow;
        logic signed [VEL_W-1:0] vcol;
    } sprite_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UPD  = 2'd1,
        ST_PUB  = 2'd2
    } motion_state_t;

    // Saturate a widened signed velocity into +/-vmax.
    function automatic logic signed [VEL_W-1:0] sat_vel(
        input logic signed [WIDE_W-1:0] v,
        input logic signed [WIDE_W-1:0] vmax
    );
        logic signed [WIDE_W-1:0] r;
        if (v > vmax)       r = vmax;
        else if (v < -vmax) r = -vmax;
        else                r = v;
        return VEL_W'(r);
    endfunction

    // Clamp an unsigned position into [lo, hi].
    function automatic logic [WIDE_W-1:0] clamp_pos(
        input logic [WIDE_W-1:0] p,
        input logic [WIDE_W-1:0] lo,
        input logic [WIDE_W-1:0] hi
    );
        if (p < lo)      return lo;
        else if (p > hi) return hi;
        else             return p;
    endfunction

endpackage

// File: rtl/axis_integrator.sv
// Combinational single-axis update: applies acceleration with velocity
// saturation, integrates position and reflects velocity off either wall.
// Ports: pos/vel in, accel, wall limits min_pos/max_pos; pos_next/vel_next out.
module axis_integrator
    import physics_pkg::*;
#(
    parameter int unsigned POS_W = 11,
    parameter int unsigned VMAX  = 31
) (
    input  logic [POS_W-1:0]        pos,
    input  logic signed [VEL_W-1:0] vel,
    input  logic signed [VEL_W-1:0] accel,
    input  logic [POS_W-1:0]        min_pos,
    input  logic [POS_W-1:0]        max_pos,
    output logic [POS_W-1:0]        pos_next,
    output logic signed [VEL_W-1:0] vel_next
);

    localparam int unsigned SUM_W = POS_W + 2;

    logic signed [WIDE_W-1:0] vel_sum;
    logic signed [VEL_W-1:0]  vel_sat;
    logic signed [SUM_W-1:0]  npos;
    logic signed [SUM_W-1:0]  lo;
    logic signed [SUM_W-1:0]  hi;

    always_comb begin
        vel_sum  = {{(WIDE_W-VEL_W){vel[VEL_W-1]}}, vel}
                 + {{(WIDE_W-VEL_W){accel[VEL_W-1]}}, accel};
        vel_sat  = sat_vel(vel_sum, WIDE_W'(VMAX));
        npos     = {2'b00, pos} + {{(SUM_W-VEL_W){vel_sat[VEL_W-1]}}, vel_sat};
        lo       = {2'b00, min_pos};
        hi       = {2'b00, max_pos};
        pos_next = POS_W'(npos);
        vel_next = vel_sat;
        // Hitting a wall pins the centre on it and reverses the axis velocity.
        if (npos < lo) begin
            pos_next = min_pos;
            vel_next = -vel_sat;
        end else if (npos > hi) begin
            pos_next = max_pos;
            vel_next = -vel_sat;
        end
    end

endmodule

// File: rtl/sprite_motion_engine.sv
// Per-frame sprite physics: on each enabled VSYNC fall, steps four sprites
// one per cycle, then publishes all positions at once to a shadow copy.
// Ports: clock_162/rst (sync, active-high), vsync_n, enable, load_* host
// placement port with load_ready handshake, sprite_row/sprite_col published
// centres, busy, frame_count.
module sprite_motion_engine
    import physics_pkg::*;
#(
    parameter int          GRAVITY = 1,
    parameter int unsigned VMAX    = 31,
    parameter int unsigned MIN_ROW = 63,
    parameter int unsigned MAX_ROW = 1136,
    parameter int unsigned MIN_COL = 63,
    parameter int unsigned MAX_COL = 1536
) (
    input  logic                                clock_162,
    input  logic                                rst,
    input  logic                                vsync_n,
    input  logic                                enable,
    input  logic                                load_valid,
    output logic                                load_ready,
    input  logic [IDX_W-1:0]                    load_idx,
    input  logic [ROW_W-1:0]                    load_row,
    input  logic [COL_W-1:0]                    load_col,
    input  logic [VEL_W-1:0]                    load_vrow,
    input  logic [VEL_W-1:0]                    load_vcol,
    output logic [NUM_SPRITES-1:0][ROW_W-1:0]   sprite_row,
    output logic [NUM_SPRITES-1:0][COL_W-1:0]   sprite_col,
    output logic                                busy,
    output logic [FRAME_W-1:0]                  frame_count
);

    motion_state_t   state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic            prev_vsync_n;
    logic            tick_pending;
    logic            tick;
    logic            load_fire;
    sprite_state_t   load_state;
    sprite_state_t   work [NUM_SPRITES];
    sprite_state_t   cur;
    logic [ROW_W-1:0]        row_next;
    logic [COL_W-1:0]        col_next;
    logic signed [VEL_W-1:0] vrow_next;
    logic signed [VEL_W-1:0] vcol_next;

    function automatic sprite_state_t reset_sprite(input int i);
        sprite_state_t s;
        s.row  = ROW_W'(200);
        s.col  = COL_W'(200 + 400 * i);
        s.vrow = VEL_W'(0);
        s.vcol = VEL_W'(2);
        return s;
    endfunction

    assign tick      = prev_vsync_n & ~vsync_n & enable;
    assign load_fire = load_valid & load_ready;
    assign cur       = work[idx];

    // Host load image: positions clamped to the walls, velocities saturated.
    always_comb begin
        load_state.row  = ROW_W'(clamp_pos(WIDE_W'(load_row), WIDE_W'(MIN_ROW), WIDE_W'(MAX_ROW)));
        load_state.col  = COL_W'(clamp_pos(WIDE_W'(load_col), WIDE_W'(MIN_COL), WIDE_W'(MAX_COL)));
        load_state.vrow = sat_vel({{(WIDE_W-VEL_W){load_vrow[VEL_W-1]}}, load_vrow}, WIDE_W'(VMAX));
        load_state.vcol = sat_vel({{(WIDE_W-VEL_W){load_vcol[VEL_W-1]}}, load_vcol}, WIDE_W'(VMAX));
    end

    axis_integrator #(.POS_W(ROW_W), .VMAX(VMAX)) u_row_axis (
        .pos      (cur.row),
        .vel      (cur.vrow),
        .accel    (VEL_W'(GRAVITY)),
        .min_pos  (ROW_W'(MIN_ROW)),
        .max_pos  (ROW_W'(MAX_ROW)),
        .pos_next (row_next),
        .vel_next (vrow_next)
    );

    axis_integrator #(.POS_W(COL_W), .VMAX(VMAX)) u_col_axis (
        .pos      (cur.col),
        .vel      (cur.vcol),
        .accel    (VEL_W'(0)),
        .min_pos  (COL_W'(MIN_COL)),
        .max_pos  (COL_W'(MAX_COL)),
        .pos_next (col_next),
        .vel_next (vcol_next)
    );

    // Sequencer next state. A tick arriving in IDLE starts the update at
    // once; tick_pending only carries ticks that land while busy.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        unique case (state)
            ST_IDLE: begin
                if (tick_pending || tick) begin
                    state_next = ST_UPD;
                    idx_next   = '0;
                end
            end
            ST_UPD: begin
                if (idx == IDX_W'(NUM_SPRITES - 1)) state_next = ST_PUB;
                else                                idx_next   = idx + IDX_W'(1);
            end
            ST_PUB:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State, working set, shadow and status registers.
    always_ff @(posedge clock_162) begin
        if (rst) begin
            state        <= ST_IDLE;
            idx          <= '0;
            prev_vsync_n <= 1'b1;
            tick_pending <= 1'b0;
            busy         <= 1'b0;
            load_ready   <= 1'b1;
            frame_count  <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                work[i]       <= reset_sprite(i);
                sprite_row[i] <= reset_sprite(i).row;
                sprite_col[i] <= reset_sprite(i).col;
            end
        end else begin
            state        <= state_next;
            idx          <= idx_next;
            prev_vsync_n <= vsync_n;
            busy         <= (state_next != ST_IDLE);
            load_ready   <= (state_next == ST_IDLE);

            // Single-depth: consumed whenever IDLE, extra ticks while set are dropped.
            if (state == ST_IDLE)  tick_pending <= 1'b0;
            else if (tick)         tick_pending <= 1'b1;

            if (load_fire)         work[load_idx] <= load_state;

            if (state == ST_UPD)   work[idx] <= '{row: row_next, col: col_next,
                                                   vrow: vrow_next, vcol: vcol_next};

            if (state == ST_PUB) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    sprite_row[i] <= work[i].row;
                    sprite_col[i] <= work[i].col;
                end
                frame_count <= frame_count + FRAME_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sprite_motion_engine.sv
// Self-checking bench for sprite_motion_engine: directed vectors, timing
// sequences and randomized loads checked against an integer physics model.
module tb_sprite_motion_engine;

    localparam int VMAX    = 31;
    localparam int GRAV    = 1;
    localparam int MIN_ROW = 63;
    localparam int MAX_ROW = 1136;
    localparam int MIN_COL = 63;
    localparam int MAX_COL = 1536;

    logic              clock_162 = 1'b0;
    logic              rst;
    logic              vsync_n;
    logic              enable;
    logic              load_valid;
    logic              load_ready;
    logic [1:0]        load_idx;
    logic [10:0]       load_row;
    logic [11:0]       load_col;
    logic [7:0]        load_vrow;
    logic [7:0]        load_vcol;
    logic [3:0][10:0]  sprite_row;
    logic [3:0][11:0]  sprite_col;
    logic              busy;
    logic [15:0]       frame_count;

    sprite_motion_engine dut (
        .clock_162  (clock_162),
        .rst        (rst),
        .vsync_n    (vsync_n),
        .enable     (enable),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_idx   (load_idx),
        .load_row   (load_row),
        .load_col   (load_col),
        .load_vrow  (load_vrow),
        .load_vcol  (load_vcol),
        .sprite_row (sprite_row),
        .sprite_col (sprite_col),
        .busy       (busy),
        .frame_count(frame_count)
    );

    always #3 clock_162 = ~clock_162;

    int tests = 0;
    int fails = 0;

    // Reference model: plain integers, working set plus published copy.
    int m_row [4];
    int m_col [4];
    int m_vrow[4];
    int m_vcol[4];
    int m_srow[4];
    int m_scol[4];
    int m_frames;

    typedef struct {
        int idx;
        int row;
        int col;
        int vrow;
        int vcol;
        int exp_row;
        int exp_col;
    } vec_t;

    vec_t vecs[5];

    function automatic int sat(input int v);
        if (v > VMAX)  return VMAX;
        if (v < -VMAX) return -VMAX;
        return v;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_row[i]  = 200;
            m_col[i]  = 200 + 400 * i;
            m_vrow[i] = 0;
            m_vcol[i] = 2;
            m_srow[i] = m_row[i];
            m_scol[i] = m_col[i];
        end
        m_frames = 0;
    endtask

    task automatic model_load(input int i, input int r, input int c, input int vr, input int vc);
        m_row[i]  = clampi(r, MIN_ROW, MAX_ROW);
        m_col[i]  = clampi(c, MIN_COL, MAX_COL);
        m_vrow[i] = sat(vr);
        m_vcol[i] = sat(vc);
    endtask

    task automatic model_frame();
        int v;
        int n;
        for (int i = 0; i < 4; i++) begin
            v = sat(m_vrow[i] + GRAV);
            n = m_row[i] + v;
            if (n < MIN_ROW)      begin m_row[i] = MIN_ROW; m_vrow[i] = -v; end
            else if (n > MAX_ROW) begin m_row[i] = MAX_ROW; m_vrow[i] = -v; end
            else                  begin m_row[i] = n;       m_vrow[i] = v;  end
            v = sat(m_vcol[i]);
            n = m_col[i] + v;
            if (n < MIN_COL)      begin m_col[i] = MIN_COL; m_vcol[i] = -v; end
            else if (n > MAX_COL) begin m_col[i] = MAX_COL; m_vcol[i] = -v; end
            else                  begin m_col[i] = n;       m_vcol[i] = v;  end
        end
        for (int i = 0; i < 4; i++) begin
            m_srow[i] = m_row[i];
            m_scol[i] = m_col[i];
        end
        m_frames = (m_frames + 1) % 65536;
    endtask

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_outputs(input string tag);
        check($sformatf("%s frame_count", tag), int'(frame_count), m_frames);
        check($sformatf("%s busy", tag), int'(busy), 0);
        check($sformatf("%s load_ready", tag), int'(load_ready), 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s row%0d", tag, i), int'(sprite_row[i]), m_srow[i]);
            check($sformatf("%s col%0d", tag, i), int'(sprite_col[i]), m_scol[i]);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock_162);
    endtask

    task automatic pulse_vsync();
        @(negedge clock_162);
        vsync_n = 1'b0;
        @(negedge clock_162);
        vsync_n = 1'b1;
    endtask

    task automatic frame();
        pulse_vsync();
        cycles(6);
        if (enable) model_frame();
    endtask

    task automatic drive_load(input int i, input int r, input int c, input int vr, input int vc);
        load_valid = 1'b1;
        load_idx   = 2'(i);
        load_row   = 11'(r);
        load_col   = 12'(c);
        load_vrow  = 8'(vr);
        load_vcol  = 8'(vc);
    endtask

    task automatic do_load(input int i, input int r, input int c, input int vr, input int vc);
        @(negedge clock_162);
        check("load_ready before load", int'(load_ready), 1);
        drive_load(i, r, c, vr, vc);
        @(negedge clock_162);
        load_valid = 1'b0;
        model_load(i, r, c, vr, vc);
    endtask

    initial begin
        rst        = 1'b1;
        vsync_n    = 1'b1;
        enable     = 1'b1;
        load_valid = 1'b0;
        load_idx   = '0;
        load_row   = '0;
        load_col   = '0;
        load_vrow  = '0;
        load_vcol  = '0;
        cycles(3);
        rst = 1'b0;
        model_reset();
        cycles(1);
        check_outputs("reset");

        // First frame with cycle-accurate visibility of busy/ready/outputs.
        pulse_vsync();
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("t+%0d busy", k), int'(busy), 1);
            check($sformatf("t+%0d load_ready", k), int'(load_ready), 0);
            check($sformatf("t+%0d row0 held", k), int'(sprite_row[0]), 200);
            check($sformatf("t+%0d frame_count held", k), int'(frame_count), 0);
            cycles(1);
        end
        check("t+6 busy", int'(busy), 0);
        check("t+6 frame_count", int'(frame_count), 1);
        check("t+6 row0", int'(sprite_row[0]), 201);
        check("t+6 col0", int'(sprite_col[0]), 202);
        model_frame();
        check_outputs("frame1");
        frame();
        check("frame2 row0", int'(sprite_row[0]), 203);
        check_outputs("frame2");

        // Directed load-then-tick vectors with hand-derived results.
        vecs[0] = '{2, 1130,  800,   10,    0, 1136,  800};
        vecs[1] = '{1,  500,   64,    0,   -5,  501,   63};
        vecs[2] = '{0,    0, 4000, -128,  127,   63, 1536};
        vecs[3] = '{3,  300,  500,  127,  127,  331,  531};
        vecs[4] = '{2, 2047,    0,    0, -128, 1136,   63};
        for (int v = 0; v < 5; v++) begin
            do_load(vecs[v].idx, vecs[v].row, vecs[v].col, vecs[v].vrow, vecs[v].vcol);
            cycles(1);
            check($sformatf("vec%0d shadow row untouched", v), int'(sprite_row[vecs[v].idx]), m_srow[vecs[v].idx]);
            frame();
            check($sformatf("vec%0d row", v), int'(sprite_row[vecs[v].idx]), vecs[v].exp_row);
            check($sformatf("vec%0d col", v), int'(sprite_col[vecs[v].idx]), vecs[v].exp_col);
            check_outputs($sformatf("vec%0d", v));
        end

        // Left-wall bounce followed by the rebound frame.
        do_load(1, 500, 64, 0, -5);
        frame();
        check("bounce col", int'(sprite_col[1]), 63);
        frame();
        check("rebound col", int'(sprite_col[1]), 68);
        check_outputs("rebound");

        // Free fall from rest: velocity saturates at 31, no bounce within 40 frames.
        do_load(3, 100, 700, 0, 0);
        for (int f = 0; f < 40; f++) begin
            frame();
            check_outputs($sformatf("fall%0d", f));
        end
        check("fall final row", int'(sprite_row[3]), 875);
        check("fall final col", int'(sprite_col[3]), 700);

        // Load and VSYNC fall in the same cycle: update uses the loaded values.
        @(negedge clock_162);
        check("ready at load+tick", int'(load_ready), 1);
        vsync_n = 1'b0;
        drive_load(0, 400, 400, -3, 4);
        @(negedge clock_162);
        vsync_n    = 1'b1;
        load_valid = 1'b0;
        model_load(0, 400, 400, -3, 4);
        cycles(6);
        model_frame();
        check("load+tick row0", int'(sprite_row[0]), 398);
        check("load+tick col0", int'(sprite_col[0]), 404);
        check_outputs("load+tick");

        // Frozen motion: ticks ignored while enable is low.
        enable = 1'b0;
        repeat (3) frame();
        enable = 1'b1;
        check_outputs("disabled");

        // Ticks while busy: one is latched, a further one is dropped.
        pulse_vsync();
        @(negedge clock_162); vsync_n = 1'b0;
        @(negedge clock_162); vsync_n = 1'b1;
        @(negedge clock_162); vsync_n = 1'b0;
        @(negedge clock_162); vsync_n = 1'b1;
        cycles(10);
        model_frame();
        model_frame();
        check_outputs("pending");

        // Randomized loads and frames, occasionally with a tick queued while busy.
        for (int it = 0; it < 30; it++) begin
            int nl;
            nl = int'($urandom_range(0, 2));
            for (int l = 0; l < nl; l++)
                do_load(int'($urandom_range(0, 3)), int'($urandom_range(0, 2047)),
                        int'($urandom_range(0, 4095)), int'($urandom_range(0, 255)) - 128,
                        int'($urandom_range(0, 255)) - 128);
            if ($urandom_range(0, 3) == 0) begin
                pulse_vsync();
                @(negedge clock_162); vsync_n = 1'b0;
                @(negedge clock_162); vsync_n = 1'b1;
                cycles(12);
                model_frame();
                model_frame();
            end else begin
                frame();
            end
            check_outputs($sformatf("rand%0d", it));
        end

        // Reset in the middle of an update restores everything.
        pulse_vsync();
        cycles(2);
        rst = 1'b1;
        @(negedge clock_162);
        rst = 1'b0;
        model_reset();
        check_outputs("midreset");
        cycles(8);
        check_outputs("midreset settle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
